// File: rtl/serial_encoder_pkg.sv
// serial_encoder_pkg: shared FSM state type and index-width helper (package enc_pkg)
// ENC_STATE_W : width of the encoder state register
// enc_state_t : ENC_IDLE (accepting loads) / ENC_EMIT (streaming indices)
// enc_idx_w(n): index width for an n-bit vector, $clog2(n) with a floor of 1
package enc_pkg;
    localparam int ENC_STATE_W = 1;
    typedef enum logic [ENC_STATE_W-1:0] {ENC_IDLE, ENC_EMIT} enc_state_t;
    function automatic int enc_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/serial_encoder_if.sv
// serial_encoder_if: load and emit handshake bundle for serial_encoder
// slave  : encoder side (takes in_valid/in/out_ready, drives the rest)
// master : producer/consumer side
// in_valid/in_ready/in        load handshake and request vector
// out_valid/out_ready/x/out_last  index stream, one index per beat
// busy                        encoder is emitting
// err                         sticky dropped-request flag, only with SERIAL_ENCODER_ERR_EN
interface serial_encoder_if #(parameter int N_IN = 16);
    import enc_pkg::*;
    localparam int W_IDX = enc_idx_w(N_IN);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in;
    logic             out_valid;
    logic             out_ready;
    logic [W_IDX-1:0] x;
    logic             out_last;
    logic             busy;
`ifdef SERIAL_ENCODER_ERR_EN
    logic             err;
    modport slave  (input in_valid, in, out_ready, output in_ready, out_valid, x, out_last, busy, err);
    modport master (output in_valid, in, out_ready, input in_ready, out_valid, x, out_last, busy, err);
`else
    modport slave  (input in_valid, in, out_ready, output in_ready, out_valid, x, out_last, busy);
    modport master (output in_valid, in, out_ready, input in_ready, out_valid, x, out_last, busy);
`endif
endinterface

// File: rtl/serial_encoder_prio_enc.sv
// prio_enc: combinational priority encoder with set-bit and one-hot detection
// vec   : input vector
// idx   : lowest set index (LSB_FIRST=1) or highest (LSB_FIRST=0), 0 when vec == 0
// found : vec has at least one bit set
// single: vec has exactly one bit set
module prio_enc
    import enc_pkg::*;
#(
    parameter int N_IN = 16,
    parameter bit LSB_FIRST = 1,
    localparam int W_IDX = enc_idx_w(N_IN)
) (
    input  logic [N_IN-1:0]  vec,
    output logic [W_IDX-1:0] idx,
    output logic             found,
    output logic             single
);
    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};
    // Scan from the low-priority end so the winning bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (vec[LSB_FIRST ? N_IN-1-i : i]) idx = W_IDX'(LSB_FIRST ? N_IN-1-i : i);
        end
    end
    assign found  = |vec;
    assign single = found && ((vec & (vec - ONE)) == '0);
endmodule

// File: rtl/serial_encoder.sv
// serial_encoder: latches a multi-hot request vector and emits each set index, one per beat
// clk : rising-edge clock
// rst : asynchronous active-high reset
// bus : serial_encoder_if.slave (load handshake, index stream, busy)
// Optional: define SERIAL_ENCODER_ERR_EN for the sticky bus.err flag
module serial_encoder
    import enc_pkg::*;
#(
    parameter int N_IN = 16,
    parameter bit LSB_FIRST = 1
) (
    input logic             clk,
    input logic             rst,
    serial_encoder_if.slave bus
);
    localparam int W_IDX = enc_idx_w(N_IN);
    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};
    enc_state_t       state, state_nxt;
    logic [N_IN-1:0]  pending, pend_nxt;
    logic [W_IDX-1:0] x_q, idx;
    logic             last_q, found, single;
    // The output registers are loaded from the encoder of the value pending will hold
    // after this edge, so X and Out_Last are ready the cycle after a load or beat.
    prio_enc #(.N_IN(N_IN), .LSB_FIRST(LSB_FIRST)) u_prio (
        .vec   (pend_nxt),
        .idx   (idx),
        .found (found),
        .single(single)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ENC_IDLE;
        else     state <= state_nxt;
    end
    // A zero load leaves nothing pending, so it naturally stays IDLE; the last
    // beat empties pending and returns to IDLE the same way.
    always_comb begin
        pend_nxt  = (state == ENC_IDLE && bus.in_valid)  ? bus.in :
                    (state == ENC_EMIT && bus.out_ready) ? pending & ~(ONE << x_q) : pending;
        state_nxt = found ? ENC_EMIT : ENC_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            x_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            x_q     <= idx;
            last_q  <= single;
        end
    end
    assign bus.in_ready  = (state == ENC_IDLE);
    assign bus.busy      = (state == ENC_EMIT);
    assign bus.out_valid = (state == ENC_EMIT);
    assign bus.x         = x_q;
    assign bus.out_last  = last_q;
`ifdef SERIAL_ENCODER_ERR_EN
    logic err_q;
    // Flags a zero load accepted in IDLE, or any request arriving while emitting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (bus.in_valid && (state == ENC_EMIT || bus.in == '0));
    end
    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_serial_encoder.sv
// tb_serial_encoder: randomized self-checking bench for serial_encoder (three configurations)
module tb_serial_encoder;
    typedef int int_q[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b0;
    logic [15:0] drv_in = '0;
    int          total = 0;
    int          passed = 0;
    logic        obs_valid, obs_ready, obs_last, obs_busy;
    logic [3:0]  obs_x;

    always #5 clk = ~clk;

    // a: N_IN=16 LSB first, b: N_IN=16 MSB first, c: N_IN=5 LSB first
    serial_encoder_if #(.N_IN(16)) ia();
    serial_encoder_if #(.N_IN(16)) ib();
    serial_encoder_if #(.N_IN(5))  ic();
    serial_encoder #(.N_IN(16), .LSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    serial_encoder #(.N_IN(16), .LSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    serial_encoder #(.N_IN(5),  .LSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    assign ia.in_valid = drv_valid && sel == 0;
    assign ib.in_valid = drv_valid && sel == 1;
    assign ic.in_valid = drv_valid && sel == 2;
    assign ia.out_ready = drv_ready && sel == 0;
    assign ib.out_ready = drv_ready && sel == 1;
    assign ic.out_ready = drv_ready && sel == 2;
    assign ia.in = drv_in;
    assign ib.in = drv_in;
    assign ic.in = drv_in[4:0];
    assign obs_valid = sel == 2 ? ic.out_valid : sel == 1 ? ib.out_valid : ia.out_valid;
    assign obs_ready = sel == 2 ? ic.in_ready  : sel == 1 ? ib.in_ready  : ia.in_ready;
    assign obs_last  = sel == 2 ? ic.out_last  : sel == 1 ? ib.out_last  : ia.out_last;
    assign obs_busy  = sel == 2 ? ic.busy      : sel == 1 ? ib.busy      : ia.busy;
    assign obs_x     = sel == 2 ? {1'b0, ic.x} : sel == 1 ? ib.x         : ia.x;

    // Reference: the set bit positions of v, in the order they must be emitted.
    function automatic int_q order(input logic [15:0] v, input int n, input bit lsb);
        int_q q;
        for (int i = 0; i < n; i++)
            if (v[i]) begin
                if (lsb) q.push_back(i);
                else q.push_front(i);
            end
        return q;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at the negedge after the last beat.
    task automatic run_load(input int s, input logic [15:0] v, input logic [31:0] pat,
                            input bit rnd, input bit noise, input string tag);
        int_q q;
        int   j;
        bit   r;
        sel = s;
        q = order(v, s == 2 ? 5 : 16, s != 1);
        total++;
        if (obs_ready !== 1'b1) $display("FAIL %s in_ready before load: got %b want 1", tag, obs_ready);
        else passed++;
        drv_in = v;
        drv_valid = 1'b1;
        drv_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        j = 0;
        while (q.size() > 0 && j < 200) begin
            total++;
            if (obs_valid !== 1'b1 || obs_x !== 4'(q[0]) || obs_last !== (q.size() == 1) ||
                obs_busy !== 1'b1 || obs_ready !== 1'b0)
                $display("FAIL %s cycle %0d: valid=%b x=%0d last=%b busy=%b in_ready=%b want 1 %0d %b 1 0",
                         tag, j, obs_valid, obs_x, obs_last, obs_busy, obs_ready, q[0], q.size() == 1);
            else passed++;
            r = rnd ? 1'($urandom_range(0, 1)) : (j < 32 ? pat[j] : 1'b1);
            drv_ready = r;
            drv_valid = noise;
            drv_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (r) void'(q.pop_front());
            j++;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        total++;
        if (q.size() != 0) $display("FAIL %s timeout: %0d indices still expected, want 0", tag, q.size());
        else passed++;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_x !== 4'd0 || obs_last !== 1'b0)
            $display("FAIL %s idle after: valid=%b in_ready=%b busy=%b x=%0d last=%b want 0 1 0 0 0",
                     tag, obs_valid, obs_ready, obs_busy, obs_x, obs_last);
        else passed++;
    endtask

    task automatic test_reset;
        sel = 0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_x !== 4'd0)
            $display("FAIL reset_hold: valid=%b in_ready=%b busy=%b x=%0d want 0 1 0 0", obs_valid, obs_ready, obs_busy, obs_x);
        else passed++;
`ifdef SERIAL_ENCODER_ERR_EN
        total++;
        if (ia.err !== 1'b0 || ib.err !== 1'b0 || ic.err !== 1'b0)
            $display("FAIL reset_err: got %b%b%b want 000", ia.err, ib.err, ic.err);
        else passed++;
`endif
        rst = 1'b0;
        drv_in = 16'h00F0;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        total++;
        if (obs_valid !== 1'b1 || obs_x !== 4'd4)
            $display("FAIL reset_preload: valid=%b x=%0d want 1 4", obs_valid, obs_x);
        else passed++;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_x !== 4'd0 || obs_last !== 1'b0)
            $display("FAIL reset_async: valid=%b in_ready=%b busy=%b x=%0d last=%b want 0 1 0 0 0",
                     obs_valid, obs_ready, obs_busy, obs_x, obs_last);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_x !== 4'd0)
            $display("FAIL reset_release: valid=%b in_ready=%b busy=%b x=%0d want 0 1 0 0", obs_valid, obs_ready, obs_busy, obs_x);
        else passed++;
    endtask

    task automatic test_single;
        run_load(0, 16'h0001, '1, 1'b0, 1'b0, "single");
    endtask

    task automatic test_stream;
        run_load(0, 16'h8421, '1, 1'b0, 1'b0, "stream_lsb");
    endtask

    task automatic test_msb_backpressure;
        run_load(1, 16'h8421, 32'hFFFF_FFF9, 1'b0, 1'b0, "msb_backpressure");
    endtask

    task automatic test_npow2;
        run_load(2, 16'h0010, '1, 1'b0, 1'b0, "npow2_bit4");
        run_load(2, 16'h0000, '1, 1'b0, 1'b0, "npow2_zero");
        run_load(2, 16'h001F, '1, 1'b0, 1'b0, "npow2_all");
`ifdef SERIAL_ENCODER_ERR_EN
        total++;
        if (ic.err !== 1'b1) $display("FAIL npow2_err: got %b want 1", ic.err);
        else passed++;
`endif
    endtask

    task automatic test_dropped;
        run_load(1, 16'h0F0F, '1, 1'b0, 1'b1, "dropped");
`ifdef SERIAL_ENCODER_ERR_EN
        total++;
        if (ib.err !== 1'b1 || ia.err !== 1'b0) $display("FAIL dropped_err: got b=%b a=%b want 1 0", ib.err, ia.err);
        else passed++;
`endif
    endtask

    task automatic test_back_to_back;
        run_load(0, 16'h0003, '1, 1'b0, 1'b0, "b2b_first");
        run_load(0, 16'hC000, '1, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid;
        sel = 0;
        drv_in = 16'hFFFF;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_valid !== 1'b1 || obs_x !== 4'(k))
                $display("FAIL reset_mid beat %0d: valid=%b x=%0d want 1 %0d", k, obs_valid, obs_x, k);
            else passed++;
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_ready !== 1'b1)
            $display("FAIL reset_mid_async: valid=%b busy=%b in_ready=%b want 0 0 1", obs_valid, obs_busy, obs_ready);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        drv_ready = 1'b0;
        @(negedge clk);
`ifdef SERIAL_ENCODER_ERR_EN
        total++;
        if (ia.err !== 1'b0 || ib.err !== 1'b0 || ic.err !== 1'b0)
            $display("FAIL reset_mid_err: got %b%b%b want 000", ia.err, ib.err, ic.err);
        else passed++;
`endif
        run_load(0, 16'h0002, '1, 1'b0, 1'b0, "reset_mid_reload");
    endtask

    task automatic test_random;
        int          s;
        logic [15:0] v;
        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(0, 2);
            v = 16'($urandom);
            if (s == 2) v = v & 16'h001F;
            if ($urandom_range(0, 7) == 0) v = '0;
            run_load(s, v, '1, 1'b1, 1'($urandom_range(0, 1)), $sformatf("random%0d", k));
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_stream;
        test_msb_backpressure;
        test_npow2;
        test_dropped;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_encoder.md
Name: serial_encoder

Overview:
- Parametrised, registered successor to the combinational 16-to-4 encoder.
- Accepts a multi-hot request vector and latches it.
- Emits the index of every set bit, one per handshake beat, in priority order.
- Sits between request-gathering logic (interrupt/arbiter front ends) and index-consuming logic that takes one index per transfer.

Parameters:
- N_IN, 16: input vector width; must be >= 2; need not be a power of two.
- LSB_FIRST, 1: 1 = lowest set index emitted first; 0 = highest set index emitted first.
- W_IDX, $clog2(N_IN): localparam, not overridable; index width.

Ports:
- Clk  in  1  clock, rising-edge.
- Rst  in  1  reset, asynchronous, active-high.
- In_Valid  in  1  load request.
- In_Ready  out  1  block can accept a load.
- In  in  N_IN  request vector; sampled only on load accept.
- Out_Valid  out  1  X holds a valid index.
- Out_Ready  in  1  consumer accepts X.
- X  out  W_IDX  emitted index.
- Out_Last  out  1  current X is the final pending bit of this load.
- Busy  out  1  state == EMIT.

Behaviour:
- Fixed clocking: one clock Clk; reset Rst is asynchronous and active-high.
- State register holds IDLE or EMIT. Pending register is N_IN bits.
- Reset values: state = IDLE, pending = 0, Out_Valid = 0, X = 0, Out_Last = 0. In_Ready = 1 and Busy = 0 as soon as Rst asserts.
- In_Ready = (state == IDLE); Busy = (state == EMIT). Both decode only the state register.
- Load (IDLE, In_Valid = 1):
  - In != 0: pending <= In; state <= EMIT. Out_Valid, X and Out_Last are registered from In at the same edge.
  - Latency: accept at edge k, so Out_Valid = 1 from edge k onward; first index is visible the cycle after accept.
  - In == 0: load is consumed and dropped; state stays IDLE; In_Ready stays 1.
- Emit (EMIT):
  - X = priority index of pending: lowest set bit if LSB_FIRST = 1, highest set bit if LSB_FIRST = 0.
  - Out_Last = 1 iff popcount(pending) == 1.
- Beat (Out_Valid = 1 and Out_Ready = 1 at an edge):
  - Clear bit X in pending.
  - If Out_Last: state <= IDLE, Out_Valid <= 0, X <= 0, Out_Last <= 0.
  - Otherwise: register the next index and Last flag from the updated pending.
- Throughput: one index per cycle while Out_Ready is held high.
- Backpressure: while Out_Valid = 1 and Out_Ready = 0, X, Out_Last and pending stay stable.
- No overlap: In_Valid is ignored while in EMIT. In_Ready returns high the cycle after the Last beat; a new load can be accepted at the following edge.
- X never exceeds N_IN-1, including non-power-of-two N_IN.
- Reset mid-operation: pending is discarded immediately; no further beats are emitted.
- Out_Valid never asserts with pending == 0.

Optional Feature:
- Macro SERIAL_ENCODER_ERR_EN.
- Defined:
  - Adds output port Err (1 bit), reset 0.
  - Err is sticky: set at any accepted load with In == 0, and at any In_Valid = 1 cycle while in EMIT (dropped request).
  - Err clears only on Rst.
- Undefined: no Err port; both conditions are silently ignored. All other behaviour is identical.

Decomposition:
- Package enc_pkg:
  - state typedef enc_state_t {ENC_IDLE, ENC_EMIT}.
  - Constant ENC_STATE_W.
  - Function enc_idx_w(n) returning $clog2(n), minimum 1.
- Sub-module prio_enc (combinational):
  - Parameters N_IN and LSB_FIRST.
  - Input vector; outputs idx (W_IDX), found and single (popcount == 1).
  - Instantiated once on the next-pending value. It is also the natural unit to test standalone.

Test Plan:
- Reset/idle: assert Rst mid-cycle -> immediately In_Ready = 1, Out_Valid = 0, X = 0, Busy = 0; Rst released -> values hold.
- Single bit, N_IN = 16: load 16'h0001 with Out_Ready = 1 -> one beat X = 0, Out_Last = 1; In_Ready = 1 on the following cycle.
- Multi-bit streaming, LSB_FIRST = 1: load 16'h8421 with Out_Ready = 1 -> X = 0, 5, 10, 15 on consecutive cycles; Out_Last only with X = 15.
- Priority order and backpressure, LSB_FIRST = 0: load 16'h8421; toggle Out_Ready 1,0,0,1,1,1 -> sequence 15, 10, 5, 0; X held stable during the 0 cycles.
- Non-power-of-two width, N_IN = 5: load 5'b10000 -> X = 3'd4; load 5'b00000 -> no Out_Valid; with SERIAL_ENCODER_ERR_EN, Err = 1.
- Reset mid-stream: load 16'hFFFF, assert Rst after the 3rd beat -> Out_Valid = 0 at once; after release, load 16'h0002 -> X = 1 only.
